serial_addsub_ctrl: RTL and testbench
=====================================

// Module: serial_addsub_ctrl
// PURPOSE
//  Sequences one shared 2-bit add/sub slice to add or subtract WIDTH-bit operands, two bits per cycle, LSB first.
//  Carry/borrow is chained through a register between digits.
//  Accepts an operation over a valid/ready handshake and returns sum, borrow/carry and signed overflow over a second handshake.
//  Sits between the operand source (switches/FSM) and the result display path.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; even, >= 2; NDIG = WIDTH/2 digit cycles per operation
// PORTS
//  clk          in   1      system clock, all state updates on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  start_valid  in   1      operation request present
//  start_ready  out  1      block can accept a request (high only in IDLE)
//  a            in   WIDTH  operand A, sampled at start handshake
//  b            in   WIDTH  operand B, sampled at start handshake
//  mode         in   1      0 = add (a+b), 1 = subtract (a-b), sampled at start handshake
//  res_valid    out  1      result fields valid (high only in DONE)
//  res_ready    in   1      consumer takes the result
//  sum          out  WIDTH  result, modulo 2**WIDTH
//  cbout        out  1      add: carry out of MSB; subtract: borrow (1 when a < b unsigned)
//  ovf          out  1      two's-complement overflow (carry into MSB XOR carry out of MSB)
//  busy         out  1      high in RUN
// BEHAVIOUR
//  Reset: one clock only; reset is synchronous and active-low (rst_n sampled on clk rising edge).
//  When rst_n is low at a clk rising edge: state = IDLE; sum, cbout, ovf, res_valid, busy = 0; start_ready = 1; digit counter = 0; carry reg = 0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - start_ready = 1.
//   - On start_valid at edge T: latch a, b, mode; carry reg <= mode (two's-complement +1 for subtract).
//   - sum reg <= 0; counter <= 0; go to RUN.
//  RUN (edges T+1 .. T+NDIG):
//   - Digit i = counter.
//   - Slice inputs: a[2i+1:2i], b[2i+1:2i] XOR {2{mode}}, cin = carry reg.
//   - Slice sum is written to sum[2i+1:2i]; carry reg <= slice cout.
//   - On the last digit (counter == NDIG-1): cbout <= cout XOR mode; ovf <= (carry into bit WIDTH-1) XOR cout; go to DONE.
//  DONE:
//   - res_valid = 1; sum/cbout/ovf stay stable until the handshake.
//   - On res_ready: go to IDLE; res_valid drops at that edge.
//  Outputs are registered; no combinational path from a/b/mode to the result.
//  Latency: start handshake at edge T -> res_valid high after edge T+NDIG (NDIG cycles).
//  Throughput: one operation per NDIG+2 cycles when res_ready is held high.
//  Boundaries:
//   - start_valid is ignored outside IDLE; a/b/mode changes during RUN/DONE have no effect.
//   - res_ready is ignored outside DONE.
//   - Back-pressure: DONE holds indefinitely; start_ready stays 0.
//   - WIDTH = 2: RUN lasts exactly one cycle.
//   - Counter wraps only via the DONE->IDLE path; never exceeds NDIG-1.
//   - rst_n low in RUN or DONE aborts the operation; no result is produced; reset values apply at that edge.
// STRUCTURE
//  Package addsub_pkg: state_t enum {IDLE, RUN, DONE}; localparams MODE_ADD = 1'b0, MODE_SUB = 1'b1.
//  Sub-module addsub_slice: 2-bit ripple adder built from two fulladder instances.
//   - Ports: ain[1:0], bin[1:0], cin -> sout[1:0], cout, cmsb (carry into bit 1).
//   - Exactly one instance; no other arithmetic in the controller.
// TESTING (WIDTH=8, res_ready=1 unless stated)
//  1 a=0x5A, b=0x3C, mode=0 -> sum=0x96, cbout=0, ovf=1; res_valid exactly 4 cycles after accept.
//  2 a=0x10, b=0x20, mode=1 -> sum=0xF0, cbout=1, ovf=0. Then a=0x80, b=0x01, mode=1 -> sum=0x7F, cbout=0, ovf=1.
//  3 a=0xFF, b=0x01, mode=0 -> sum=0x00, cbout=1, ovf=0. Then a=0x33, b=0x33, mode=1 -> sum=0x00, cbout=0, ovf=0.
//  4 res_ready low for 10 cycles in DONE -> res_valid, sum, cbout, ovf stable; start_ready=0; start_valid pulses ignored.
//  5 rst_n low on 2nd RUN cycle -> next edge: IDLE, res_valid=0, start_ready=1, sum=0; following op 0x01+0x02 -> 0x03.
//  6 start_valid held high with changing a/b during RUN -> result matches operands sampled at accept only.

Source files
------------

// File: rtl/addsub_pkg.sv
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared state encoding and mode constants for the serial
//                add/subtract controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/addsub_slice.sv
// ============================================================================
//  Module      : fulladder / addsub_slice
//  Description : Single-bit full adder and the 2-bit ripple slice built from it.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fulladder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module addsub_slice (
   input  logic [1:0] ain,
   input  logic [1:0] bin,
   input  logic       cin,
   output logic [1:0] sout,
   output logic       cout,
   output logic       cmsb
);

   // cmsb is the carry into bit 1, needed by the controller for overflow
   fulladder u_fa0 (.a(ain[0]), .b(bin[0]), .ci(cin),  .s(sout[0]), .co(cmsb));
   fulladder u_fa1 (.a(ain[1]), .b(bin[1]), .ci(cmsb), .s(sout[1]), .co(cout));

endmodule

`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
// ============================================================================
//  Module      : serial_addsub_ctrl
//  Description : Adds/subtracts WIDTH-bit operands two bits per cycle, LSB
//                first, through one shared 2-bit slice with a carry register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_addsub_ctrl
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cbout,
   output logic             ovf,
   output logic             busy
);

   localparam int NDIG = WIDTH / 2;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             mode_q, mode_d, carry_q, carry_d;
   logic             cbout_q, cbout_d, ovf_q, ovf_d;

   logic [1:0]       dig_a, dig_b, dig_s;
   logic             dig_cout, dig_cmsb;

   always_comb begin
      dig_a = '0;
      dig_b = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (cnt_q == CW'(i)) begin
            dig_a = a_q[2*i +: 2];
            dig_b = b_q[2*i +: 2];
         end
      end
   end

   // Subtraction is a + ~b + 1; the +1 enters through the preset carry register
   addsub_slice u_slice (
      .ain  (dig_a),
      .bin  (dig_b ^ {2{mode_q == MODE_SUB}}),
      .cin  (carry_q),
      .sout (dig_s),
      .cout (dig_cout),
      .cmsb (dig_cmsb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cbout_d = cbout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               a_d     = a;
               b_d     = b;
               mode_d  = mode;
               carry_d = mode;
               sum_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NDIG; i++) begin
               if (cnt_q == CW'(i)) sum_d[2*i +: 2] = dig_s;
            end
            carry_d = dig_cout;
            if (cnt_q == LAST) begin
               cbout_d = dig_cout ^ mode_q;
               ovf_d   = dig_cmsb ^ dig_cout;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cbout_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cbout_q <= cbout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign start_ready = (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign busy        = (state_q == RUN);
   assign sum         = sum_q;
   assign cbout       = cbout_q;
   assign ovf         = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
// ============================================================================
//  Module      : tb_serial_addsub_ctrl
//  Description : Directed self-checking bench for serial_addsub_ctrl, WIDTH=8.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             mode = 1'b0;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [WIDTH-1:0] sum;
   logic             cbout;
   logic             ovf;
   logic             busy;

   int n_chk  = 0;
   int n_pass = 0;

   serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .mode        (mode),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .sum         (sum),
      .cbout       (cbout),
      .ovf         (ovf),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Present an operation and take the accept edge; start_valid optionally left high
   task automatic accept(input logic [7:0] ta, input logic [7:0] tb_, input logic tm,
                         input logic keep, input string tag);
      a = ta; b = tb_; mode = tm; start_valid = 1'b1;
      chk({tag, "_ready"}, 32'(start_ready), 32'd1);
      tick();
      if (!keep) start_valid = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      while (!res_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      chk({tag, "_lat"}, 32'(cyc), 32'd4);
   endtask

   task automatic check_res(input logic [7:0] es, input logic ec, input logic eo, input string tag);
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cb"}, 32'(cbout), 32'(ec));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
   endtask

   task automatic op(input logic [7:0] ta, input logic [7:0] tb_, input logic tm,
                     input logic [7:0] es, input logic ec, input logic eo, input string tag);
      accept(ta, tb_, tm, 1'b0, tag);
      wait_done(tag);
      check_res(es, ec, eo, tag);
      tick();
      chk({tag, "_idle"}, 32'({start_ready, res_valid}), 32'b10);
   endtask

   initial begin
      logic [10:0] snap;

      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_flags", 32'({start_ready, res_valid, busy}), 32'b100);
      chk("rst_res", 32'({sum, cbout, ovf}), 32'd0);
      rst_n = 1'b1;
      tick();

      op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1, "t1");
      op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0, "t2a");
      op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, "t2b");
      op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "t3a");
      op(8'h33, 8'h33, 1'b1, 8'h00, 1'b0, 1'b0, "t3b");

      // Back-pressure: DONE must hold with inputs wiggling
      res_ready = 1'b0;
      accept(8'h7F, 8'h7F, 1'b0, 1'b0, "t4");
      wait_done("t4");
      check_res(8'hFE, 1'b0, 1'b1, "t4");
      snap = {res_valid, start_ready, sum, cbout};
      for (int k = 0; k < 10; k++) begin
         start_valid = k[0];
         a = 8'(k * 37);
         b = 8'(k * 11);
         mode = k[1];
         tick();
         chk("t4_hold", 32'({res_valid, start_ready, sum, cbout, ovf}), 32'({snap, 1'b1}));
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      chk("t4_release", 32'({start_ready, res_valid}), 32'b10);

      // Reset on the second RUN cycle aborts the operation
      accept(8'h55, 8'h11, 1'b0, 1'b0, "t5");
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_flags", 32'({start_ready, res_valid, busy}), 32'b100);
      chk("t5_sum", 32'(sum), 32'd0);
      op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "t5b");

      // Operands sampled only at accept
      accept(8'h12, 8'h34, 1'b0, 1'b1, "t6");
      for (int k = 0; k < 20 && !res_valid; k++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         mode = 1'($urandom);
         tick();
      end
      check_res(8'h46, 1'b0, 1'b0, "t6");
      start_valid = 1'b0;
      tick();
      chk("t6_idle", 32'({start_ready, res_valid}), 32'b10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
